scp_zone_escalator: RTL and testbench

Multi-zone containment-alarm controller: watches N zones, each reporting a green/yellow/red status level, and escalates through a timed state machine that drives the security, database and control-system alarm outputs. Parametrised successor to the single-zone alarm FSM. Adds per-zone fault detection, worst-zone arbitration, operator acknowledge, a lockdown state and timed recovery. Sits between the zone sensor front-ends and the facility alarm drivers.

---
 rtl/scp_zone_escalator_pkg.sv | 31 +++
 rtl/scp_zone_escalator_if.sv | 32 +++
 rtl/scp_zone_decode.sv | 36 +++
 rtl/scp_zone_escalator.sv | 147 ++++++++++++++
 tb/tb_scp_zone_escalator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scp_zone_escalator_pkg.sv
// Shared encodings for the multi-zone containment-alarm escalator:
// FSM state codes, zone level codes and the Moore alarm decode.
package scp_zone_escalator_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WATCH    = 3'd1;
    localparam logic [2:0] ST_ALERT    = 3'd2;
    localparam logic [2:0] ST_BREACH   = 3'd3;
    localparam logic [2:0] ST_LOCKDOWN = 3'd4;
    localparam logic [2:0] ST_RECOVER  = 3'd5;

    // Level codes are ordered so that a numeric compare ranks severity.
    localparam logic [1:0] LVL_GREEN  = 2'd0;
    localparam logic [1:0] LVL_YELLOW = 2'd1;
    localparam logic [1:0] LVL_RED    = 2'd2;

    typedef struct packed {
        logic security;
        logic database;
        logic control_sys;
    } alarms_t;

    function automatic alarms_t alarm_decode(input logic [2:0] st);
        alarms_t a;
        a.security    = (st == ST_ALERT) || (st == ST_BREACH) || (st == ST_LOCKDOWN);
        a.database    = (st == ST_BREACH) || (st == ST_LOCKDOWN);
        a.control_sys = (st == ST_LOCKDOWN);
        return a;
    endfunction

endpackage

// File: rtl/scp_zone_escalator_if.sv
// Bundle of zone status inputs, operator ack and alarm/status outputs
// between the zone front-ends (master) and the escalator (slave).
interface scp_zone_escalator_if #(
    parameter int N_ZONES = 4,
    parameter int TW      = 8
);
    localparam int AZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

    logic [N_ZONES-1:0] green;
    logic [N_ZONES-1:0] yellow;
    logic [N_ZONES-1:0] red;
    logic               ack;
    logic               a_security;
    logic               a_database;
    logic               a_control_sys;
    logic [2:0]         state;
    logic [TW-1:0]      timer;
    logic [AZW-1:0]     active_zone;
    logic [N_ZONES-1:0] zone_fault;

    modport master (
        output green, yellow, red, ack,
        input  a_security, a_database, a_control_sys,
        input  state, timer, active_zone, zone_fault
    );

    modport slave (
        input  green, yellow, red, ack,
        output a_security, a_database, a_control_sys,
        output state, timer, active_zone, zone_fault
    );
endinterface

// File: rtl/scp_zone_decode.sv
// Per-zone status decode: a clean one-hot reading gives its level; any
// other pattern is flagged as a fault and treated as yellow.
module scp_zone_decode
    import scp_zone_escalator_pkg::*;
(
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    output logic [1:0] level,
    output logic       fault
);

    always_comb begin
        level = LVL_YELLOW;
        fault = 1'b1;
        case ({green, yellow, red})
            3'b100: begin
                level = LVL_GREEN;
                fault = 1'b0;
            end
            3'b010: begin
                level = LVL_YELLOW;
                fault = 1'b0;
            end
            3'b001: begin
                level = LVL_RED;
                fault = 1'b0;
            end
            default: begin
                level = LVL_YELLOW;
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/scp_zone_escalator.sv
// Multi-zone alarm escalator: worst-zone arbitration feeding a timed
// IDLE/WATCH/ALERT/BREACH/LOCKDOWN/RECOVER state machine with Moore alarms.
module scp_zone_escalator
    import scp_zone_escalator_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int TW        = 8,
    parameter int T_YELLOW  = 20,
    parameter int T_RED     = 10,
    parameter int T_LOCK    = 30,
    parameter int T_RECOVER = 5
) (
    input  logic                  clock,
    input  logic                  rst_n,
    scp_zone_escalator_if.slave   bus
);

    localparam int AZW     = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int TIM_MAX = (TW >= 1 && TW <= 31) ? ((1 << TW) - 1) : 0;

    generate
        if (N_ZONES < 1 || TW < 1 || TW > 31 ||
            T_YELLOW  < 1 || T_YELLOW  > TIM_MAX ||
            T_RED     < 1 || T_RED     > TIM_MAX ||
            T_LOCK    < 1 || T_LOCK    > TIM_MAX ||
            T_RECOVER < 1 || T_RECOVER > TIM_MAX) begin : g_param_check
            $error("scp_zone_escalator: illegal parameter set");
        end
    endgenerate

    localparam logic [TW-1:0] YELLOW_LAST  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] RED_LAST     = TW'(T_RED - 1);
    localparam logic [TW-1:0] LOCK_LAST    = TW'(T_LOCK - 1);
    localparam logic [TW-1:0] RECOVER_LAST = TW'(T_RECOVER - 1);

    logic [1:0]         zone_level [N_ZONES];
    logic [N_ZONES-1:0] zone_fault_d, zone_fault_q;
    logic [1:0]         worst_level;
    logic [AZW-1:0]     active_zone_d, active_zone_q;
    logic [2:0]         state_d, state_q;
    logic [TW-1:0]      timer_d, timer_q;
    alarms_t            alarms;

    generate
        for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
            scp_zone_decode u_decode (
                .green  (bus.green[gi]),
                .yellow (bus.yellow[gi]),
                .red    (bus.red[gi]),
                .level  (zone_level[gi]),
                .fault  (zone_fault_d[gi])
            );
        end
    endgenerate

    // Strictly-greater compare keeps the lowest index among equally bad zones.
    always_comb begin
        worst_level   = LVL_GREEN;
        active_zone_d = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (zone_level[i] > worst_level) begin
                worst_level   = zone_level[i];
                active_zone_d = AZW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (worst_level == LVL_YELLOW)
                    state_d = ST_WATCH;
                else if (worst_level == LVL_RED)
                    state_d = ST_ALERT;
            end
            ST_WATCH: begin
                if (worst_level == LVL_GREEN)
                    state_d = ST_IDLE;
                else if (worst_level == LVL_RED)
                    state_d = ST_ALERT;
                else if (timer_q == YELLOW_LAST)
                    state_d = ST_ALERT;
            end
            ST_ALERT: begin
                if (worst_level == LVL_GREEN)
                    state_d = ST_RECOVER;
                else if (worst_level == LVL_RED && timer_q == RED_LAST)
                    state_d = ST_BREACH;
            end
            ST_BREACH: begin
                if (bus.ack)
                    state_d = ST_RECOVER;
                else if (timer_q == LOCK_LAST)
                    state_d = ST_LOCKDOWN;
            end
            ST_LOCKDOWN: begin
                if (bus.ack && worst_level == LVL_GREEN)
                    state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (worst_level == LVL_YELLOW)
                    state_d = ST_WATCH;
                else if (worst_level == LVL_RED)
                    state_d = ST_ALERT;
                else if (timer_q == RECOVER_LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALERT only counts red time; a yellow dip pauses the count rather than resetting it.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == ST_ALERT && worst_level != LVL_RED)
            timer_d = timer_q;
        else if (timer_q != {TW{1'b1}})
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            zone_fault_q  <= '0;
            active_zone_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            zone_fault_q  <= zone_fault_d;
            active_zone_q <= active_zone_d;
        end
    end

    assign alarms            = alarm_decode(state_q);
    assign bus.a_security    = alarms.security;
    assign bus.a_database    = alarms.database;
    assign bus.a_control_sys = alarms.control_sys;
    assign bus.state         = state_q;
    assign bus.timer         = timer_q;
    assign bus.active_zone   = active_zone_q;
    assign bus.zone_fault    = zone_fault_q;

endmodule

// File: tb/tb_scp_zone_escalator.sv
// Bench for scp_zone_escalator: vector table plus hand-written escalation
// sequences, expectations queued at drive time and popped after each edge.
module tb_scp_zone_escalator;

    localparam int N  = 4;
    localparam int TW = 8;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    scp_zone_escalator_if #(.N_ZONES(N), .TW(TW)) bus ();

    scp_zone_escalator #(
        .N_ZONES(N), .TW(TW), .T_YELLOW(20), .T_RED(10), .T_LOCK(30), .T_RECOVER(5)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [TW-1:0] tm;
        logic [1:0]    az;
        logic [N-1:0]  zf;
        logic          sec;
        logic          db;
        logic          cs;
    } obs_t;

    typedef struct {
        logic [11:0] gyr;
        logic        ack;
        logic [2:0]  st;
        logic [7:0]  tm;
        logic [1:0]  az;
        logic [3:0]  zf;
    } vec_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[25];

    // Expected alarms follow the state table: ALERT+ security, BREACH+ database, LOCKDOWN control.
    function automatic obs_t mk(input logic [2:0] st, input logic [7:0] tm,
                                input logic [1:0] az, input logic [3:0] zf);
        obs_t o;
        o.st  = st;
        o.tm  = tm;
        o.az  = az;
        o.zf  = zf;
        o.sec = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        o.db  = (st == 3'd3) || (st == 3'd4);
        o.cs  = (st == 3'd4);
        return o;
    endfunction

    // Two bits per zone (zone 0 in the LSBs): 0 green, 1 yellow, 2 red.
    function automatic logic [11:0] enc(input logic [7:0] lv);
        logic [3:0] g, y, r;
        g = '0; y = '0; r = '0;
        for (int i = 0; i < 4; i++) begin
            case (lv[2*i +: 2])
                2'd0:    g[i] = 1'b1;
                2'd1:    y[i] = 1'b1;
                default: r[i] = 1'b1;
            endcase
        end
        return {g, y, r};
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st  = bus.state;
        o.tm  = bus.timer;
        o.az  = bus.active_zone;
        o.zf  = bus.zone_fault;
        o.sec = bus.a_security;
        o.db  = bus.a_database;
        o.cs  = bus.a_control_sys;
        return o;
    endfunction

    task automatic check(input string name);
        obs_t e, a;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        a = observe();
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d tm=%0d az=%0d zf=%b alm=%b%b%b, required st=%0d tm=%0d az=%0d zf=%b alm=%b%b%b",
                     name, a.st, a.tm, a.az, a.zf, a.sec, a.db, a.cs,
                     e.st, e.tm, e.az, e.zf, e.sec, e.db, e.cs);
        end else begin
            $display("ok   %s: st=%0d tm=%0d az=%0d zf=%b alm=%b%b%b",
                     name, a.st, a.tm, a.az, a.zf, a.sec, a.db, a.cs);
        end
    endtask

    task automatic step(input logic [11:0] gyr, input logic a, input logic [2:0] st,
                        input logic [7:0] tm, input logic [1:0] az, input logic [3:0] zf,
                        input string name);
        bus.green  = gyr[11:8];
        bus.yellow = gyr[7:4];
        bus.red    = gyr[3:0];
        bus.ack    = a;
        exp_q.push_back(mk(st, tm, az, zf));
        @(posedge clock);
        #1;
        check(name);
    endtask

    task automatic recover_to_idle(input string tag);
        step(enc(8'h00), 1'b0, 3'd5, 8'd0, 2'd0, 4'h0, {tag, "_rec0"});
        for (int k = 1; k <= 4; k++)
            step(enc(8'h00), 1'b0, 3'd5, 8'(k), 2'd0, 4'h0, $sformatf("%s_rec%0d", tag, k));
        step(enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0, {tag, "_idle"});
    endtask

    task automatic to_lockdown(input string tag);
        step(enc(8'h02), 1'b0, 3'd2, 8'd0, 2'd0, 4'h0, {tag, "_alert"});
        for (int k = 1; k <= 9; k++)
            step(enc(8'h02), 1'b0, 3'd2, 8'(k), 2'd0, 4'h0, $sformatf("%s_alert%0d", tag, k));
        step(enc(8'h02), 1'b0, 3'd3, 8'd0, 2'd0, 4'h0, {tag, "_breach"});
        for (int k = 1; k <= 29; k++)
            step(enc(8'h02), 1'b0, 3'd3, 8'(k), 2'd0, 4'h0, $sformatf("%s_breach%0d", tag, k));
        step(enc(8'h02), 1'b0, 3'd4, 8'd0, 2'd0, 4'h0, {tag, "_lockdown"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vector table: {g,y,r} inputs, ack, then expected state/timer/zone/fault after the edge.
        tbl[0]  = '{enc(8'h00), 1'b0, 3'd0, 8'd1, 2'd0, 4'h0};
        tbl[1]  = '{enc(8'h00), 1'b1, 3'd0, 8'd2, 2'd0, 4'h0};
        tbl[2]  = '{enc(8'h04), 1'b0, 3'd1, 8'd0, 2'd1, 4'h0};
        tbl[3]  = '{enc(8'h04), 1'b0, 3'd1, 8'd1, 2'd1, 4'h0};
        tbl[4]  = '{enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0};
        tbl[5]  = '{enc(8'h80), 1'b0, 3'd2, 8'd0, 2'd3, 4'h0};
        tbl[6]  = '{enc(8'h80), 1'b0, 3'd2, 8'd1, 2'd3, 4'h0};
        tbl[7]  = '{enc(8'h40), 1'b0, 3'd2, 8'd1, 2'd3, 4'h0};
        tbl[8]  = '{enc(8'h80), 1'b0, 3'd2, 8'd2, 2'd3, 4'h0};
        tbl[9]  = '{enc(8'h00), 1'b0, 3'd5, 8'd0, 2'd0, 4'h0};
        tbl[10] = '{enc(8'h01), 1'b0, 3'd1, 8'd0, 2'd0, 4'h0};
        tbl[11] = '{{4'b1011, 4'b0000, 4'b0000}, 1'b0, 3'd1, 8'd1, 2'd2, 4'b0100};
        tbl[12] = '{enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0};
        tbl[13] = '{enc(8'h09), 1'b0, 3'd2, 8'd0, 2'd1, 4'h0};
        tbl[14] = '{enc(8'h88), 1'b0, 3'd2, 8'd1, 2'd1, 4'h0};
        tbl[15] = '{enc(8'h00), 1'b0, 3'd5, 8'd0, 2'd0, 4'h0};
        tbl[16] = '{enc(8'h20), 1'b0, 3'd2, 8'd0, 2'd2, 4'h0};
        tbl[17] = '{enc(8'h00), 1'b0, 3'd5, 8'd0, 2'd0, 4'h0};
        tbl[18] = '{enc(8'h00), 1'b0, 3'd5, 8'd1, 2'd0, 4'h0};
        tbl[19] = '{enc(8'h00), 1'b0, 3'd5, 8'd2, 2'd0, 4'h0};
        tbl[20] = '{enc(8'h00), 1'b0, 3'd5, 8'd3, 2'd0, 4'h0};
        tbl[21] = '{enc(8'h00), 1'b0, 3'd5, 8'd4, 2'd0, 4'h0};
        tbl[22] = '{enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0};
        tbl[23] = '{{4'b1111, 4'b0000, 4'b0001}, 1'b0, 3'd1, 8'd0, 2'd0, 4'b0001};
        tbl[24] = '{enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0};

        // Reset with every zone floating: nothing may register while rst_n is low.
        bus.green  = '0;
        bus.yellow = '0;
        bus.red    = '0;
        bus.ack    = 1'b0;
        #12;
        exp_q.push_back(mk(3'd0, 8'd0, 2'd0, 4'h0));
        check("reset_init");
        bus.green = 4'hF;
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++)
            step(tbl[i].gyr, tbl[i].ack, tbl[i].st, tbl[i].tm, tbl[i].az, tbl[i].zf,
                 $sformatf("vec%0d", i));

        // Yellow on zone 2: WATCH for 20 cycles, then ALERT.
        step(enc(8'h10), 1'b0, 3'd1, 8'd0, 2'd2, 4'h0, "yel_watch");
        for (int k = 1; k <= 19; k++)
            step(enc(8'h10), 1'b0, 3'd1, 8'(k), 2'd2, 4'h0, $sformatf("yel_watch%0d", k));
        step(enc(8'h10), 1'b0, 3'd2, 8'd0, 2'd2, 4'h0, "yel_alert");
        recover_to_idle("yel");

        // Red on zone 0 all the way to LOCKDOWN; ack only releases once green.
        to_lockdown("red");
        step(enc(8'h02), 1'b1, 3'd4, 8'd1, 2'd0, 4'h0, "lock_ack_red");
        step(enc(8'h00), 1'b0, 3'd4, 8'd2, 2'd0, 4'h0, "lock_green_noack");
        step(enc(8'h00), 1'b1, 3'd5, 8'd0, 2'd0, 4'h0, "lock_green_ack");
        for (int k = 1; k <= 4; k++)
            step(enc(8'h00), 1'b0, 3'd5, 8'(k), 2'd0, 4'h0, $sformatf("lock_rec%0d", k));
        step(enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0, "lock_idle");

        // One-cycle ack in BREACH at timer 7.
        step(enc(8'h02), 1'b0, 3'd2, 8'd0, 2'd0, 4'h0, "bra_alert");
        for (int k = 1; k <= 9; k++)
            step(enc(8'h02), 1'b0, 3'd2, 8'(k), 2'd0, 4'h0, $sformatf("bra_alert%0d", k));
        step(enc(8'h02), 1'b0, 3'd3, 8'd0, 2'd0, 4'h0, "bra_breach");
        for (int k = 1; k <= 7; k++)
            step(enc(8'h02), 1'b0, 3'd3, 8'(k), 2'd0, 4'h0, $sformatf("bra_breach%0d", k));
        step(enc(8'h02), 1'b1, 3'd5, 8'd0, 2'd0, 4'h0, "bra_ack");
        for (int k = 1; k <= 4; k++)
            step(enc(8'h00), 1'b0, 3'd5, 8'(k), 2'd0, 4'h0, $sformatf("bra_rec%0d", k));
        step(enc(8'h00), 1'b0, 3'd0, 8'd0, 2'd0, 4'h0, "bra_idle");

        // Zone 1 green+yellow (fault), zone 3 red; then zone 3 clears.
        step({4'b0111, 4'b0010, 4'b1000}, 1'b0, 3'd2, 8'd0, 2'd3, 4'b0010, "flt_alert");
        step({4'b0111, 4'b0010, 4'b1000}, 1'b0, 3'd2, 8'd1, 2'd3, 4'b0010, "flt_alert1");
        step({4'b1111, 4'b0010, 4'b0000}, 1'b0, 3'd2, 8'd1, 2'd1, 4'b0010, "flt_hold");
        step({4'b1111, 4'b0010, 4'b0000}, 1'b0, 3'd2, 8'd1, 2'd1, 4'b0010, "flt_hold2");
        recover_to_idle("flt");

        // Red arriving on the same cycle as the WATCH timeout: a single move to ALERT.
        step(enc(8'h01), 1'b0, 3'd1, 8'd0, 2'd0, 4'h0, "sim_watch");
        for (int k = 1; k <= 19; k++)
            step(enc(8'h01), 1'b0, 3'd1, 8'(k), 2'd0, 4'h0, $sformatf("sim_watch%0d", k));
        step(enc(8'h02), 1'b0, 3'd2, 8'd0, 2'd0, 4'h0, "sim_alert");
        step(enc(8'h02), 1'b0, 3'd2, 8'd1, 2'd0, 4'h0, "sim_alert1");
        recover_to_idle("sim");

        // Long LOCKDOWN dwell saturates the timer, then reset lands mid-LOCKDOWN.
        to_lockdown("sat");
        for (int k = 1; k <= 260; k++)
            step(enc(8'h00), 1'b0, 3'd4, (k > 255) ? 8'd255 : 8'(k), 2'd0, 4'h0,
                 $sformatf("sat_lock%0d", k));
        bus.ack = 1'b1;
        rst_n   = 1'b0;
        #2;
        exp_q.push_back(mk(3'd0, 8'd0, 2'd0, 4'h0));
        check("reset_async");
        @(posedge clock);
        #1;
        exp_q.push_back(mk(3'd0, 8'd0, 2'd0, 4'h0));
        check("reset_held");
        rst_n = 1'b1;
        step(enc(8'h00), 1'b0, 3'd0, 8'd1, 2'd0, 4'h0, "post_reset_idle");
        step(enc(8'h04), 1'b0, 3'd1, 8'd0, 2'd1, 4'h0, "post_reset_watch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
